// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stopwatch_ctrl: button conditioning, run/lap/pause FSM and tick prescaler |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic StartStop_btn,
  input  logic Lap_btn,
  input  logic Clear_btn,
  output logic Enable,
  output logic Clear,
  output logic Freeze,
  output logic Running
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int DW       = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {Clear_btn, Lap_btn, StartStop_btn};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;
    logic          press_q;
    logic          press_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // The count only advances while the synced sample disagrees with the
    // accepted level; a single agreeing sample starts the run over.
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      press_d = level_q & ~level_dly_q;
      if (sync2_q != level_q) begin
        if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          level_d = sync2_q;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
        sync1_q     <= 1'b0;
        sync2_q     <= 1'b0;
        level_q     <= 1'b0;
        level_dly_q <= 1'b0;
        press_q     <= 1'b0;
        cnt_q       <= '0;
      end else begin
        sync1_q     <= btn_raw[i];
        sync2_q     <= sync1_q;
        level_q     <= level_d;
        level_dly_q <= level_q;
        press_q     <= press_d;
        cnt_q       <= cnt_d;
      end
    end

    assign press[i] = press_q;
  end

  logic ss_p;
  logic lap_p;
  logic clr_p;

  assign ss_p  = press[0];
  assign lap_p = press[1];
  assign clr_p = press[2];

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          enable_q;
  logic          enable_d;
  logic          clear_q;
  logic          clear_d;
  logic          freeze_q;
  logic          freeze_d;
  logic          running_q;
  logic          running_d;
  logic          counting;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    enable_d = 1'b0;
    clear_d  = 1'b0;
    counting = (state_q == S_RUN) || (state_q == S_LAP);

    // The tick is decided by the current state, so a stop arriving on the
    // wrap cycle still emits its tick and leaves the prescaler at zero.
    if (counting) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d  = '0;
        enable_d = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (ss_p) begin
          state_d = S_RUN;
        end else if (clr_p) begin
          clear_d = 1'b1;
          presc_d = '0;
        end
      end
      S_RUN: begin
        if (ss_p) begin
          state_d = S_PAUSE;
        end else if (lap_p) begin
          state_d = S_LAP;
        end
      end
      S_LAP: begin
        if (ss_p) begin
          state_d = S_PAUSE;
        end else if (lap_p) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (ss_p) begin
          state_d = S_RUN;
        end else if (clr_p) begin
          state_d = S_IDLE;
          clear_d = 1'b1;
          presc_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN) || (state_d == S_LAP);
    freeze_d  = (state_d == S_LAP);
  end

  // Clear resets high so the counter chain sees one clear at startup.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      enable_q  <= 1'b0;
      clear_q   <= 1'b1;
      freeze_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      enable_q  <= enable_d;
      clear_q   <= clear_d;
      freeze_q  <= freeze_d;
      running_q <= running_d;
    end
  end

  assign Enable  = enable_q;
  assign Clear   = clear_q;
  assign Freeze  = freeze_q;
  assign Running = running_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stopwatch_ctrl: scoreboard bench with a cycle-level behavioural model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DB      = 4;
  localparam int PRESS_LAT = 2 + DB + 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_LAP   = 2;
  localparam int M_PAUSE = 3;

  logic clk = 1'b0;
  logic Reset_n;
  logic ss_btn;
  logic lap_btn;
  logic clr_btn;
  logic Enable;
  logic Clear;
  logic Freeze;
  logic Running;

  int n_checks = 0;
  int n_pass   = 0;
  int n_en     = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ          (CLK_HZ),
    .TICK_HZ         (TICK_HZ),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk           (clk),
    .Reset_n       (Reset_n),
    .StartStop_btn (ss_btn),
    .Lap_btn       (lap_btn),
    .Clear_btn     (clr_btn),
    .Enable        (Enable),
    .Clear         (Clear),
    .Freeze        (Freeze),
    .Running       (Running)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: button level accepted once the last DB delayed samples
  // all disagree with it; outputs reflect the state after each edge.
  int  m_state;
  int  m_phase;
  bit  m_en;
  bit  m_clr;
  bit  m_pulse [3];
  bit  m_rose  [3];
  bit  m_level [3];
  bit  m_hist  [3][2];
  bit  m_win   [3][DB];
  int  m_win_n [3];
  logic [3:0] exp_q [$];

  task automatic m_reset();
    m_state = M_IDLE;
    m_phase = 0;
    m_en    = 1'b0;
    m_clr   = 1'b1;
    for (int b = 0; b < 3; b++) begin
      m_pulse[b] = 1'b0;
      m_rose[b]  = 1'b0;
      m_level[b] = 1'b0;
      m_hist[b][0] = 1'b0;
      m_hist[b][1] = 1'b0;
      m_win_n[b] = 0;
    end
  endtask

  task automatic m_step();
    bit raw [3];
    bit ss, lp, cl, run, smp, all_diff;
    raw[0] = ss_btn; raw[1] = lap_btn; raw[2] = clr_btn;
    ss = m_pulse[0]; lp = m_pulse[1]; cl = m_pulse[2];
    run   = (m_state == M_RUN) || (m_state == M_LAP);
    m_en  = run && (m_phase == DIV - 1);
    m_clr = 1'b0;
    if (run) m_phase = (m_phase + 1) % DIV;
    case (m_state)
      M_IDLE:  if (ss) m_state = M_RUN;
               else if (cl) begin m_clr = 1'b1; m_phase = 0; end
      M_RUN:   if (ss) m_state = M_PAUSE; else if (lp) m_state = M_LAP;
      M_LAP:   if (ss) m_state = M_PAUSE; else if (lp) m_state = M_RUN;
      default: if (ss) m_state = M_RUN;
               else if (cl) begin m_state = M_IDLE; m_clr = 1'b1; m_phase = 0; end
    endcase
    for (int b = 0; b < 3; b++) begin
      m_pulse[b] = m_rose[b];
      m_rose[b]  = 1'b0;
      smp = m_hist[b][0];
      m_hist[b][0] = m_hist[b][1];
      m_hist[b][1] = raw[b];
      for (int k = DB - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
      m_win[b][0] = smp;
      if (m_win_n[b] < DB) m_win_n[b]++;
      all_diff = (m_win_n[b] == DB);
      for (int k = 0; k < DB; k++) if (m_win[b][k] == m_level[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[b] = !m_level[b];
        m_rose[b]  = m_level[b];
      end
    end
  endtask

  task automatic push_exp();
    exp_q.push_back({m_en, m_clr, m_state == M_LAP,
                     (m_state == M_RUN) || (m_state == M_LAP)});
  endtask

  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_reset();
      exp_q.delete();
      push_exp();
    end else begin
      m_step();
      push_exp();
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp;
    if (Enable === 1'b1) n_en++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("outputs{Enable,Clear,Freeze,Running}",
            {28'd0, Enable, Clear, Freeze, Running}, {28'd0, exp});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_running(input logic v, input int max, output int n);
    n = 0;
    while (Running !== v && n < max) begin
      cyc(1);
      n++;
    end
    if (Running !== v) check("wait_running_timeout", {31'd0, Running}, {31'd0, v});
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       ss_btn  = v;
      1:       lap_btn = v;
      default: clr_btn = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc(DB + 4);
    set_btn(b, 1'b0);
    cyc(DB + 4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e0;
    Reset_n = 1'b0;
    ss_btn  = 1'b0;
    lap_btn = 1'b0;
    clr_btn = 1'b0;
    cyc(3);
    check("reset_clear", {31'd0, Clear}, 32'd1);
    check("reset_running", {31'd0, Running}, 32'd0);
    Reset_n = 1'b1;
    cyc(1);
    check("clear_falls_after_reset", {31'd0, Clear}, 32'd0);

    // Bouncing start press, then a clean hold.
    for (int i = 0; i < 10; i++) begin
      ss_btn = ~ss_btn;
      cyc(2);
    end
    ss_btn = 1'b1;
    wait_running(1'b1, 30, n);
    check("press_to_running_latency", n, PRESS_LAT + 1);
    ss_btn = 1'b0;

    // 35 running cycles give three ticks, then resume after 5 cycles.
    e0 = n_en;
    cyc(35 - PRESS_LAT - 1);
    ss_btn = 1'b1;
    wait_running(1'b0, 20, n);
    check("enables_in_35_cycles", n_en - e0, 3);
    ss_btn = 1'b0;
    cyc(10);
    ss_btn = 1'b1;
    wait_running(1'b1, 20, n);
    ss_btn = 1'b0;
    e0 = n_en;
    cyc(4);
    check("resume_no_early_enable", n_en - e0, 0);
    check("resume_enable_low", {31'd0, Enable}, 32'd0);
    cyc(1);
    check("resume_enable_at_5", {31'd0, Enable}, 32'd1);
    cyc(10);

    press(1);
    check("lap_freeze_on", {31'd0, Freeze}, 32'd1);
    cyc(20);
    press(1);
    check("lap_freeze_off", {31'd0, Freeze}, 32'd0);
    press(2);
    check("clr_ignored_in_run", {31'd0, Running}, 32'd1);

    press(0);
    check("paused", {31'd0, Running}, 32'd0);
    ss_btn  = 1'b1;
    clr_btn = 1'b1;
    cyc(DB + 4);
    ss_btn  = 1'b0;
    clr_btn = 1'b0;
    cyc(DB + 4);
    check("ss_beats_clr", {31'd0, Running}, 32'd1);
    press(0);
    clr_btn = 1'b1;
    cyc(PRESS_LAT + 1);
    check("clear_pulse_high", {31'd0, Clear}, 32'd1);
    cyc(1);
    check("clear_pulse_one_cycle", {31'd0, Clear}, 32'd0);
    clr_btn = 1'b0;
    cyc(DB + 4);

    // Reset mid-LAP while a lap press is still debouncing.
    press(0);
    press(1);
    lap_btn = 1'b1;
    cyc(3);
    Reset_n = 1'b0;
    #1;
    check("async_reset_clear", {31'd0, Clear}, 32'd1);
    check("async_reset_freeze", {31'd0, Freeze}, 32'd0);
    check("async_reset_running", {31'd0, Running}, 32'd0);
    lap_btn = 1'b0;
    cyc(1);
    Reset_n = 1'b1;
    cyc(20);
    check("no_pulse_after_reset", {30'd0, Freeze, Running}, 32'd0);

    // Randomised presses, glitches, collisions and occasional resets.
    for (int it = 0; it < 250; it++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op < 12) begin
        int b;
        b = $urandom_range(0, 2);
        for (int k = 0; k < $urandom_range(0, 3); k++) begin
          set_btn(b, 1'b1); cyc($urandom_range(1, DB - 1));
          set_btn(b, 1'b0); cyc($urandom_range(1, 2));
        end
        set_btn(b, 1'b1);
        cyc($urandom_range(DB + 2, DB + 6));
        set_btn(b, 1'b0);
      end else if (op < 15) begin
        ss_btn  = 1'b1;
        lap_btn = $urandom_range(0, 1);
        clr_btn = 1'b1;
        cyc(DB + 4);
        ss_btn  = 1'b0;
        lap_btn = 1'b0;
        clr_btn = 1'b0;
      end else if (op < 18) begin
        set_btn($urandom_range(0, 2), 1'b1);
        cyc($urandom_range(1, DB));
        ss_btn  = 1'b0;
        lap_btn = 1'b0;
        clr_btn = 1'b0;
      end else if (op == 18) begin
        #2;
        Reset_n = 1'b0;
        cyc($urandom_range(1, 2));
        Reset_n = 1'b1;
      end
      cyc($urandom_range(DB + 3, 25));
    end

    cyc(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control front end of the stopwatch. It sits directly upstream of the BCD digit counter chain. It debounces the raw Start/Stop, Lap and Clear buttons and runs the stopwatch state machine. It divides the system clock into the count tick, and drives the counter chain's synchronous Enable and Reset inputs plus a display-freeze level for lap hold.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
TICK_HZ, 100, count tick rate in Hz (hundredths of a second); TICK_DIV = CLK_HZ/TICK_HZ, must be an integer ≥ 2
DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples required to accept a button level (≥ 2)

Ports:
clk  input  1  system clock, all logic on rising edge
Reset_n  input  1  asynchronous, active-low reset
StartStop_btn  input  1  raw button, asynchronous, active-high
Lap_btn  input  1  raw button, asynchronous, active-high
Clear_btn  input  1  raw button, asynchronous, active-high
Enable  output  1  one-cycle count tick to the least-significant digit counter Enable
Clear  output  1  one-cycle synchronous clear to all digit counter Reset inputs
Freeze  output  1  level; display holds its latched value while high
Running  output  1  level; high in RUN or LAP

Behaviour:
- Reset is asynchronous and active-low. While Reset_n=0: state=IDLE, prescaler=0, debouncers=released, Enable=0, Freeze=0, Running=0, Clear=1.
- Clear falls to 0 on the first clk edge after Reset_n rises, so the counters see exactly one clear edge at startup.
- Input conditioning, per button:
  - 2-FF synchronizer feeding a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it. Any matching sample restarts the count.
  - A rising edge of the debounced level gives a 1-cycle press pulse. Releases produce nothing.
  - Latency from a raw edge to the press pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
- States:
  - IDLE: stopped, counters zero.
  - RUN: counting.
  - LAP: counting, display frozen.
  - PAUSE: stopped, counters hold a nonzero value.
- Transitions take effect on the edge after the press pulse:
  - IDLE: ss→RUN; clr→IDLE with Clear pulse; lap ignored.
  - RUN: ss→PAUSE; lap→LAP; clr ignored.
  - LAP: lap→RUN; ss→PAUSE (Freeze drops); clr ignored.
  - PAUSE: ss→RUN; clr→IDLE with Clear pulse; lap ignored.
- Simultaneous pulses in one cycle resolve by priority ss > lap > clr. Lower-priority pulses in that cycle are discarded, not queued.
- Outputs are registered and follow the state: Running=1 in RUN/LAP, Freeze=1 in LAP only.
- Clear is high for exactly one cycle on the PAUSE→IDLE or IDLE→IDLE clear transition. It coincides with the cycle Running is 0.
- Prescaler, width clog2(TICK_DIV):
  - Increments each cycle in RUN/LAP.
  - At TICK_DIV-1 it wraps to 0 and Enable=1 for that one cycle.
  - First Enable after entering RUN from IDLE comes exactly TICK_DIV cycles after the state change.
  - In PAUSE the prescaler holds its value, so partial-tick time is preserved on resume.
  - Set to 0 when Clear pulses.
- Enable is never high outside RUN/LAP and never high in the same cycle as Clear.
- If a stop (ss) lands in the same cycle the prescaler would wrap, Enable is still issued that cycle and the prescaler wraps to 0.
- Reset mid-operation aborts any debounce in progress, any tick and any state, and returns to the reset values above.

Test Plan:
(Bench parameters: CLK_HZ=1000, TICK_HZ=100 → TICK_DIV=10, DEBOUNCE_CYCLES=4.)
- Reset release → Clear=1 during reset and for 0 cycles after the first edge; Enable=Freeze=Running=0; state IDLE.
- Bounce: StartStop_btn toggles every 2 cycles for 20 cycles, then holds 1 → single press pulse 7 cycles after the final stable edge; Running=1; Enable pulses every 10 cycles, first one 10 cycles after Running rises.
- Run 35 cycles, press ss → PAUSE after exactly 3 Enables with prescaler holding 5. Press ss again → next Enable 5 cycles after Running rises.
- RUN, press lap → Freeze=1 and Enable continues every 10 cycles. Press lap → Freeze=0. Press clr while running → no Clear, state unchanged.
- PAUSE, press ss and clr in the same cycle → RUN, no Clear pulse. Pause again, press clr alone → one-cycle Clear, state IDLE, prescaler 0.
- Assert Reset_n=0 for 1 cycle mid-LAP and mid-debounce → all outputs take reset values immediately (asynchronously). The in-progress press produces no pulse after release.
